stream_mux_rr: RTL and testbench

//  N-channel, DW-bit registered stream multiplexer with valid/ready handshake on every port.

---
 rtl/stream_mux_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/stream_mux_rr.sv | 125 ++++++++++++
 tb/tb_stream_mux_rr.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared constants for the stream_mux_rr stream multiplexer.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: first requester at or above ptr, wrapping.
module rr_arbiter #(
    parameter  int unsigned N_CH = 4,
    localparam int unsigned SW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [SW-1:0]   ptr,
    output logic [SW-1:0]   gnt_idx,
    output logic            gnt_vld
);

    int unsigned idx;

    // Walk from the farthest offset down so the nearest requester wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int k = int'(N_CH) - 1; k >= 0; k--) begin
            idx = (32'(ptr) + 32'(k)) % N_CH;
            if (req[SW'(idx)]) begin
                gnt_vld = 1'b1;
                gnt_idx = SW'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel registered stream mux, fixed-select or round-robin arbitration.
// Optional packet lock (in_last/out_last) enabled by STREAM_MUX_PKT_LOCK_EN.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int unsigned N_CH = 4,
    parameter  int unsigned DW   = 8,
    localparam int unsigned SW   = $clog2(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SW-1:0]        sel,
    input  logic [N_CH*DW-1:0]   in_data,
    input  logic [N_CH-1:0]      in_valid,
    output logic [N_CH-1:0]      in_ready,
    output logic [DW-1:0]        out_data,
    output logic [SW-1:0]        out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef STREAM_MUX_PKT_LOCK_EN
    ,
    input  logic [N_CH-1:0]      in_last,
    output logic                 out_last
`endif
);

    logic [DW-1:0] ch_data [N_CH];
    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] arb_idx;
    logic          arb_vld;
    logic [SW-1:0] grant_idx;
    logic          grant_vld;
    logic          load;
    logic          xfer;
    logic          pkt_end;

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_unpack
        assign ch_data[i] = in_data[i*DW +: DW];
    end

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic          lock;
    logic [SW-1:0] lock_ch;

    assign pkt_end = in_last[grant_idx];
`else
    assign pkt_end = 1'b1;
`endif

    assign load = !out_valid || out_ready;
    assign xfer = grant_vld && load;

    // Grant selection: an open packet overrides mode and sel.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (lock) begin
            grant_idx = lock_ch;
            grant_vld = in_valid[lock_ch];
        end else
`endif
        if (mode == MODE_RR) begin
            grant_idx = arb_idx;
            grant_vld = arb_vld;
        end else if ((32'(sel) < N_CH) && in_valid[sel]) begin
            grant_idx = sel;
            grant_vld = 1'b1;
        end
    end

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Output register; data and channel hold when the register drains empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (load) begin
            out_valid <= grant_vld;
            if (grant_vld) begin
                out_data <= ch_data[grant_idx];
                out_ch   <= grant_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (xfer && (mode == MODE_RR) && pkt_end) begin
            rr_ptr <= (32'(grant_idx) == N_CH - 1) ? '0 : grant_idx + SW'(1);
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    // Packet lock follows the last transferred beat's end marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock     <= 1'b0;
            lock_ch  <= '0;
            out_last <= 1'b0;
        end else if (xfer) begin
            lock     <= !pkt_end;
            lock_ch  <= grant_idx;
            out_last <= pkt_end;
        end
    end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed scenarios plus random traffic vs. a reference model.
module tb_stream_mux_rr;

    localparam int unsigned N_CH = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned SW   = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 mode;
    logic [SW-1:0]        sel;
    logic [N_CH*DW-1:0]   in_data;
    logic [N_CH-1:0]      in_valid;
    logic [N_CH-1:0]      in_ready;
    logic [DW-1:0]        out_data;
    logic [SW-1:0]        out_ch;
    logic                 out_valid;
    logic                 out_ready;
`ifdef STREAM_MUX_PKT_LOCK_EN
    logic [N_CH-1:0]      in_last;
    logic                 out_last;
`endif

    stream_mux_rr #(.N_CH(N_CH), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef STREAM_MUX_PKT_LOCK_EN
        ,
        .in_last   (in_last),
        .out_last  (out_last)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state, described in terms of the observable contract.
    bit            m_valid;
    logic [DW-1:0] m_data;
    int            m_ch;
    int            m_ptr;
    bit            m_lock;
    int            m_lock_ch;
    bit            m_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_valid   = 1'b0;
        m_data    = '0;
        m_ch      = 0;
        m_ptr     = 0;
        m_lock    = 1'b0;
        m_lock_ch = 0;
        m_last    = 1'b0;
    endtask

    function automatic int model_grant();
        if (m_lock) return in_valid[m_lock_ch] ? m_lock_ch : -1;
        if (mode == 1'b0) return (int'(sel) < int'(N_CH) && in_valid[sel]) ? int'(sel) : -1;
        for (int k = 0; k < int'(N_CH); k++) begin
            int c;
            c = (m_ptr + k) % int'(N_CH);
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    // One clock: check in_ready before the edge, advance the model, check outputs after it.
    task automatic cycle();
        int            g;
        bit            load;
        bit            last_g;
        logic [N_CH-1:0] exp_rdy;
        #1;
        load    = !m_valid || out_ready;
        g       = model_grant();
        exp_rdy = '0;
        if (g >= 0 && load) exp_rdy[g] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        last_g = 1'b1;
`ifdef STREAM_MUX_PKT_LOCK_EN
        if (g >= 0) last_g = in_last[g];
`endif
        @(posedge clk);
        if (load) begin
            if (g >= 0) begin
                m_valid   = 1'b1;
                m_data    = in_data[g*DW +: DW];
                m_ch      = g;
                m_last    = last_g;
                m_lock    = !last_g;
                m_lock_ch = g;
                if (mode && last_g) m_ptr = (g + 1) % int'(N_CH);
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("out_data", 64'(out_data), 64'(m_data));
        chk("out_ch", 64'(out_ch), 64'(m_ch));
`ifdef STREAM_MUX_PKT_LOCK_EN
        chk("out_last", 64'(out_last), 64'(m_last));
`endif
    endtask

    initial begin
        int            t3[3] = '{3, 0, 3};
        logic [DW-1:0] held;

        rst       = 1'b1;
        mode      = 1'b0;
        sel       = '0;
        in_data   = '0;
        in_valid  = '0;
        out_ready = 1'b0;
`ifdef STREAM_MUX_PKT_LOCK_EN
        in_last   = '1;
`endif
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_ch", 64'(out_ch), 64'd0);
        rst = 1'b0;

        // Fixed select of channel 2
        mode      = 1'b0;
        sel       = 2'd2;
        in_valid  = 4'b0100;
        in_data   = $urandom;
        in_data[2*DW +: DW] = 8'hA5;
        out_ready = 1'b1;
        #1;
        chk("t1_rdy", 64'(in_ready), 64'b0100);
        cycle();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_data", 64'(out_data), 64'hA5);
        chk("t1_ch", 64'(out_ch), 64'd2);

        // Round-robin with every channel valid, no stalls
        mode     = 1'b1;
        in_valid = '1;
        for (int k = 0; k < 8; k++) begin
            in_data = $urandom;
            cycle();
            chk("t2_ch", 64'(out_ch), 64'(k % 4));
            chk("t2_valid", 64'(out_valid), 64'd1);
        end

        // Move pointer to 1, then wrap between channels 3 and 0
        in_valid = 4'b0001;
        in_data  = $urandom;
        cycle();
        in_valid = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            in_data = $urandom;
            cycle();
            chk("t3_ch", 64'(out_ch), 64'(t3[k]));
        end

        // Stall for three cycles, then back-to-back resume
        in_valid  = '1;
        out_ready = 1'b0;
        held      = m_data;
        for (int k = 0; k < 3; k++) begin
            in_data = $urandom;
            cycle();
            chk("t4_hold", 64'(out_data), 64'(held));
            chk("t4_rdy", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        in_data   = $urandom;
        cycle();
        chk("t4_resume", 64'(out_valid), 64'd1);

        // Fixed select of an idle channel drains the register
        mode     = 1'b0;
        sel      = 2'd1;
        in_valid = 4'b1101;
        #1;
        chk("t5_rdy", 64'(in_ready), 64'd0);
        cycle();
        chk("t5_drain", 64'(out_valid), 64'd0);

        // Reset in the middle of a stream
        mode     = 1'b1;
        in_valid = '1;
        repeat (3) begin
            in_data = $urandom;
            cycle();
        end
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_data", 64'(out_data), 64'd0);
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef STREAM_MUX_PKT_LOCK_EN
        // Channel 1 holds the grant for a 3-beat packet while channel 2 waits
        mode     = 1'b1;
        in_valid = 4'b0110;
        for (int k = 0; k < 4; k++) begin
            in_last = (k == 0 || k == 1) ? 4'b1101 : 4'b1111;
            in_data = $urandom;
            cycle();
            chk("t6_ch", 64'(out_ch), (k < 3) ? 64'd1 : 64'd2);
        end
        in_last = '1;
`endif

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = SW'($urandom_range(0, N_CH - 1));
            in_valid  = N_CH'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
`ifdef STREAM_MUX_PKT_LOCK_EN
            in_last   = N_CH'($urandom);
`endif
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
